// File: rtl/mem_access_unit.sv
// Data-memory access stage: issues one word-aligned request per load/store, holds the
// pipeline until the memory acknowledges, and forms the MEM/WB register.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] addr_in,
    input  logic [31:0] st_data_in,
    input  logic        mem_read_in,
    input  logic [3:0]  mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        sel_wb_in,
    input  logic        flush_in,
    input  logic [31:0] pc_in,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_out,
    output logic        misalign_err,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_pc
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic [4:0]  rd_r;
    logic        rw_r;
    logic        load_r;
    logic        sel_wb_r;
    logic [31:0] pc_r;

    logic is_store_s;
    logic mem_op_s;
    logic aligned_s;
    logic legal_s;
    logic access_valid_s;
    logic bad_access_s;

    function automatic logic [3:0] store_we(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  store_we = ~(4'b0001 << off);
            3'b001:  store_we = off[1] ? 4'b0011 : 4'b1100;
            3'b010:  store_we = 4'b0000;
            default: store_we = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'b000:  store_data = {4{sd[7:0]}};
            3'b001:  store_data = {2{sd[15:0]}};
            default: store_data = sd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdat);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = rdat[7:0];
            2'b01:   b = rdat[15:8];
            2'b10:   b = rdat[23:16];
            default: b = rdat[31:24];
        endcase
        h = off[1] ? rdat[31:16] : rdat[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h000000, b};
            3'b101:  load_ext = {16'h0000, h};
            default: load_ext = rdat;
        endcase
    endfunction

    // Classify the EX/MEM entry and derive the stall request.
    always_comb begin
        is_store_s = (mem_write_in != 4'b1111);
        mem_op_s   = is_store_s || mem_read_in;
        case (funct3_in[1:0])
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = !addr_in[0];
            2'b10:   aligned_s = (addr_in[1:0] == 2'b00);
            default: aligned_s = 1'b0;
        endcase
        if (is_store_s) begin
            legal_s = !funct3_in[2] && (funct3_in[1:0] != 2'b11);
        end else begin
            case (funct3_in)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end
        access_valid_s = !flush_in && mem_op_s && aligned_s && legal_s;
        bad_access_s   = !flush_in && mem_op_s && !(aligned_s && legal_s);
        stall_out      = resetn && (((state_r == IDLE) && access_valid_s) ||
                                    ((state_r == BUSY) && !dm_ack));
    end

    // Access FSM, memory request registers and MEM/WB register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            dm_req       <= 1'b0;
            dm_we        <= 4'b1111;
            dm_addr      <= 32'h0000_0000;
            dm_wdata     <= 32'h0000_0000;
            misalign_err <= 1'b0;
            wb_data      <= 32'h0000_0000;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_pc        <= 32'h0000_0000;
            f3_r         <= 3'b000;
            off_r        <= 2'b00;
            rd_r         <= 5'd0;
            rw_r         <= 1'b0;
            load_r       <= 1'b0;
            sel_wb_r     <= 1'b0;
            pc_r         <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    misalign_err <= bad_access_s;
                    if (access_valid_s) begin
                        state_r      <= BUSY;
                        dm_req       <= 1'b1;
                        dm_addr      <= {addr_in[31:2], 2'b00};
                        dm_we        <= is_store_s ? store_we(funct3_in, addr_in[1:0]) : 4'b1111;
                        dm_wdata     <= store_data(funct3_in, st_data_in);
                        f3_r         <= funct3_in;
                        off_r        <= addr_in[1:0];
                        rd_r         <= rd_in;
                        rw_r         <= reg_write_in;
                        load_r       <= !is_store_s;
                        sel_wb_r     <= sel_wb_in;
                        pc_r         <= pc_in;
                        wb_reg_write <= 1'b0;
                    end else if (flush_in || bad_access_s) begin
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_data      <= addr_in;
                        wb_rd        <= rd_in;
                        wb_reg_write <= reg_write_in;
                        wb_pc        <= pc_in;
                    end
                end
                BUSY: begin
                    misalign_err <= 1'b0;
                    if (dm_ack) begin
                        state_r <= IDLE;
                        dm_req  <= 1'b0;
                        dm_we   <= 4'b1111;
                        // Stores retire as a WB bubble; only loads update the MEM/WB fields.
                        if (load_r) begin
                            wb_data      <= sel_wb_r ? load_ext(f3_r, off_r, dm_rdata)
                                                     : {dm_addr[31:2], off_r};
                            wb_rd        <= rd_r;
                            wb_reg_write <= rw_r;
                            wb_pc        <= pc_r;
                        end else begin
                            wb_reg_write <= 1'b0;
                        end
                    end else begin
                        wb_reg_write <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    dm_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; resetn  in  1  async reset, active-low.
REQ-002 SHALL have: addr_in  in  32  EX/MEM ALU result (access address / pass-through data); st_data_in  in  32  unaligned store data (rs2).
REQ-003 SHALL have: mem_read_in  in  1  load; mem_write_in  in  4  store flag, active-low, 4'b1111 = no store; funct3_in  in  3  access size/sign.
REQ-004 SHALL have: rd_in  in  5, reg_write_in  in  1, sel_wb_in  in  1 (1 = load result), flush_in  in  1 (EX/MEM entry is a bubble), pc_in  in  32.
REQ-005 SHALL have: dm_req  out  1, dm_we  out  4 (active-low lanes), dm_addr  out  32 (word-aligned), dm_wdata  out  32, dm_ack  in  1, dm_rdata  in  32.
REQ-006 SHALL have: stall_out  out  1 (holds EX/MEM and upstream), misalign_err  out  1, wb_data  out  32, wb_rd  out  5, wb_reg_write  out  1, wb_pc  out  32.

Function
REQ-007 SHALL implement FSM {IDLE, BUSY}; access_valid = !flush_in && (mem_read_in || mem_write_in != 4'b1111) && aligned && funct3 legal.
REQ-008 IDLE: access_valid -> BUSY next edge, latching dm_addr = {addr_in[31:2],2'b00}, dm_we, dm_wdata, funct3, addr[1:0], rd, reg_write, pc.
REQ-009 BUSY: dm_req = 1 (registered), request fields stable until ack; dm_ack = 1 -> IDLE next edge; else remain BUSY.
REQ-010 stall_out (combinational) = (IDLE && access_valid) || (BUSY && !dm_ack); deasserts in the dm_ack cycle so EX/MEM advances on the same edge the FSM returns to IDLE.
REQ-011 Minimum access latency SHALL be 2 cycles (IDLE detect, BUSY with same-cycle ack); no upper bound; each access issued exactly once.
REQ-012 Store lanes: SB (000) we = active-low on byte addr[1:0], data byte replicated x4; SH (001) we = 4'b1100 if addr[1]=0 else 4'b0011, halfword replicated x2; SW (010) we = 4'b0000; load dm_we = 4'b1111.
REQ-013 Loads: select byte/half by latched addr[1:0]; LB 000, LH 001 sign-extend; LBU 100, LHU 101 zero-extend; LW 010 full word.
REQ-014 Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (load 011/110/111, store >=011) with load/store and !flush_in: no dm_req, no stall, misalign_err = 1 for one cycle (registered), wb_reg_write = 0.
REQ-015 MEM/WB register: non-memory entry (no load/store, !flush_in) updates wb_* in one cycle with wb_data = addr_in, stall_out = 0.
REQ-016 Load completion: on dm_ack edge, wb_data = extended dm_rdata, wb_rd/wb_reg_write/wb_pc = latched; store completion: wb_reg_write = 0.
REQ-017 While stall_out = 1 in IDLE or BUSY without ack, wb_reg_write SHALL be 0 (bubble into WB); wb_data/wb_rd hold.
REQ-018 flush_in sampled only in IDLE: entry treated as bubble (no access, wb_reg_write = 0); flush_in during BUSY ignored, access completes.
REQ-019 dm_ack while IDLE SHALL be ignored.
REQ-020 wb_rd = 0 with wb_reg_write = 1 SHALL be passed unchanged (regfile discards x0).

Reset
REQ-021 resetn low SHALL asynchronously force: state IDLE, dm_req 0, dm_we 4'b1111, dm_addr 0, dm_wdata 0, misalign_err 0, wb_data 0, wb_rd 0, wb_reg_write 0, wb_pc 0.
REQ-022 Reset asserted mid-BUSY SHALL abort the access (dm_req low immediately); a later dm_ack is ignored; first post-reset cycle is IDLE.
REQ-023 stall_out SHALL be 0 during reset.

Verification
REQ-024 LW addr 0x1004, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> dm_addr 0x1004, stall 4 cycles, wb_data 0xDEADBEEF, wb_reg_write 1.
REQ-025 SB addr 0x2003, st_data 0x000000A5, same-cycle ack -> dm_we 4'b0111, dm_wdata 0xA5A5A5A5, dm_addr 0x2000, stall 1 cycle, wb_reg_write 0.
REQ-026 LB/LBU addr 0x3002, rdata 0x12F45678 -> LB wb_data 0xFFFFFFF4, LBU 0x000000F4; LH addr 0x3002 -> 0x000012F4.
REQ-027 LW addr 0x4002 -> no dm_req, stall 0, misalign_err 1 for one cycle, wb_reg_write 0.
REQ-028 ADD result 0x55 (no mem), rd 7 -> next cycle wb_data 0x55, wb_rd 7, wb_reg_write 1, stall 0; same with flush_in 1 -> wb_reg_write 0.
REQ-029 resetn low during BUSY, then dm_ack pulse -> dm_req 0 immediately, wb_* unchanged at reset values, FSM IDLE.
